// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - registered RAM plus LED/counter I/O page on the core memory bus
// Optional feature macro: FETCH_COUNT_EN adds the instruction-fetch counter at I/O offset 02.
module mem_bus_responder #(
   parameter int unsigned ADDR_BITS = 8,
   parameter logic [7:0]  IO_PAGE   = 8'hFF
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic [15:0] mem_add,
   input  logic [15:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_oe,
   input  logic        mem_fetch,
   output logic [15:0] mem_rdata,
   output logic        mem_rvalid,
   output logic [7:0]  led_out
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   logic [15:0]          ram [0:DEPTH-1];
   logic                 ram_sel;
   logic                 io_sel;
   logic [7:0]           io_off;
   logic [ADDR_BITS-1:0] ram_idx;
   logic [15:0]          cycles;
   logic [15:0]          io_rd;
   logic [15:0]          rd_next;
   logic                 led_wr;
   logic                 cyc_wr;

   // RAM wins if a parameter choice ever makes the two windows overlap.
   assign ram_sel = ((mem_add >> ADDR_BITS) == 16'd0);
   assign io_sel  = !ram_sel && (mem_add[15:8] == IO_PAGE);
   assign io_off  = mem_add[7:0];
   assign ram_idx = mem_add[ADDR_BITS-1:0];
   assign led_wr  = mem_we && io_sel && (io_off == 8'h00);
   assign cyc_wr  = mem_we && io_sel && (io_off == 8'h01);

`ifdef FETCH_COUNT_EN
   logic [15:0] fetches;
   logic        fch_wr;

   assign fch_wr = mem_we && io_sel && (io_off == 8'h02);

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         fetches <= 16'h0000;
      end else if (fch_wr) begin
         fetches <= mem_wdata;
      end else if (mem_oe && mem_fetch) begin
         fetches <= fetches + 16'd1;
      end
   end
`else
   logic fetch_unused;
   assign fetch_unused = mem_fetch;
`endif

   always_comb begin
      io_rd = 16'h0000;
      case (io_off)
         8'h00:   io_rd = {8'h00, led_out};
         8'h01:   io_rd = cycles;
`ifdef FETCH_COUNT_EN
         8'h02:   io_rd = fetches;
`endif
         default: io_rd = 16'h0000;
      endcase
   end

   // Reads sample the pre-write state, which gives read-first behaviour for free.
   always_comb begin
      rd_next = 16'h0000;
      if (ram_sel) begin
         rd_next = ram[ram_idx];
      end else if (io_sel) begin
         rd_next = io_rd;
      end
   end

   always_ff @(posedge clock_in) begin
      if (mem_we && ram_sel) begin
         ram[ram_idx] <= mem_wdata;
      end
   end

   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         mem_rdata  <= 16'h0000;
         mem_rvalid <= 1'b0;
         led_out    <= 8'h00;
         cycles     <= 16'h0000;
      end else begin
         mem_rvalid <= mem_oe;
         if (mem_oe) begin
            mem_rdata <= rd_next;
         end
         if (led_wr) begin
            led_out <= mem_wdata[7:0];
         end
         cycles <= cyc_wr ? mem_wdata : cycles + 16'd1;
      end
   end

endmodule
